// File: rtl/mic_pkg.sv
// mic_pkg: shared widths, PCM limits, FSM state type and magnitude helper
package mic_pkg;
  localparam int IN_W = 18;
  localparam int OUT_W = 16;
  localparam logic signed [OUT_W-1:0] PCM_MIN = 16'sh8000;
  localparam logic signed [OUT_W-1:0] PCM_MAX = 16'sh7fff;
  typedef enum logic [1:0] {IDLE, CAPTURE, PREFETCH, READOUT} state_t;
  function automatic logic [OUT_W-2:0] pcm_mag(input logic signed [OUT_W-1:0] x);
    logic signed [OUT_W-1:0] m;
    m = (x == PCM_MIN) ? PCM_MAX : (x < 0 ? -x : x);
    return m[OUT_W-2:0];
  endfunction
endpackage

// File: rtl/pcm_round_sat.sv
// pcm_round_sat: round-half-up 18-bit mic sample to 16-bit PCM with positive saturation
module pcm_round_sat
  import mic_pkg::*;
(
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);
  logic [IN_W:0] s;
  logic unused_lsb;
  assign s = {din[IN_W-1], din} + (IN_W+1)'(2);
  assign unused_lsb = ^s[1:0];
  // only +131071 (and +131070) overflow after the shift; the negative end lands exactly on PCM_MIN
  assign dout = (!s[IN_W] && s[IN_W-1]) ? PCM_MAX : s[OUT_W+1:2];
endmodule

// File: rtl/mic_capture_buffer.sv
// mic_capture_buffer: capture DEPTH converted mic samples into RAM, then stream them out
module mic_capture_buffer #(
  parameter int DEPTH = 1024,
  parameter int AW = 10,
  parameter int IN_W = 18,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_sample,
  input  logic             in_valid,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [OUT_W-2:0] peak,
  output logic [AW:0]      wr_count
);
  import mic_pkg::*;
  state_t state;
  logic [OUT_W-1:0] mem [DEPTH];
  logic [OUT_W-1:0] pcm;
  logic [OUT_W-2:0] mag;
  logic [AW-1:0] rd_ptr;
  logic wr_en;
  pcm_round_sat u_conv (.din(in_sample), .dout(pcm));
  assign mag = pcm_mag(pcm);
  assign wr_en = (state == CAPTURE) && in_valid;
  // sample RAM write port, kept reset-free so it maps onto block RAM
  always_ff @(posedge clk)
    if (wr_en) mem[wr_count[AW-1:0]] <= pcm;
  // control FSM; the next word is read on each handshake so readout has no bubbles
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
      rd_ptr <= '0;
      peak <= '0;
      wr_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= CAPTURE;
            busy <= 1'b1;
            wr_count <= '0;
            peak <= '0;
          end
        end
        CAPTURE: if (in_valid) begin
          wr_count <= wr_count + 1'b1;
          peak <= (mag > peak) ? mag : peak;
          if (wr_count == (AW+1)'(DEPTH-1)) state <= PREFETCH;
        end
        PREFETCH: begin
          rd_data <= mem[AW'(0)];
          rd_valid <= 1'b1;
          rd_ptr <= '0;
          state <= READOUT;
        end
        READOUT: if (rd_ready) begin
          if (rd_ptr == AW'(DEPTH-1)) begin
            rd_valid <= 1'b0;
            done <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end else begin
            rd_ptr <= rd_ptr + 1'b1;
            rd_data <= mem[rd_ptr + 1'b1];
          end
        end
      endcase
    end
endmodule
